// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus controller: register addresses,
// controller state encoding and the post-reset baud divisor.
package spart_pkg;

  localparam logic [15:0] DIV_RESET = 16'd325;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  typedef logic [2:0] spart_state_t;

  localparam spart_state_t ST_CFG_LO  = 3'd0;
  localparam spart_state_t ST_CFG_HI  = 3'd1;
  localparam spart_state_t ST_IDLE    = 3'd2;
  localparam spart_state_t ST_RX_RD   = 3'd3;
  localparam spart_state_t ST_TX_WR   = 3'd4;
  localparam spart_state_t ST_TX_WAIT = 3'd5;

endpackage

// File: rtl/spart_bus_ctrl_if.sv
// System-side handshakes of the SPART bus controller: two transmit
// requesters, the receive byte stream and divisor reconfiguration.
interface spart_bus_ctrl_if;

  logic       tx0_valid;
  logic [7:0] tx0_data;
  logic       tx0_ready;
  logic       tx1_valid;
  logic [7:0] tx1_data;
  logic       tx1_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cfg_valid;
  logic [15:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_done;

  modport master (
    output tx0_valid, tx0_data, tx1_valid, tx1_data, cfg_valid, cfg_div,
    input  tx0_ready, tx1_ready, rx_valid, rx_data, cfg_ready, cfg_done
  );

  modport slave (
    input  tx0_valid, tx0_data, tx1_valid, tx1_data, cfg_valid, cfg_div,
    output tx0_ready, tx1_ready, rx_valid, rx_data, cfg_ready, cfg_done
  );

endinterface

// File: rtl/spart_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant from the valid requests, the
// priority pointer moves only when the grant is actually taken.
module spart_rr_arb
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // ptr_q = 1 means requester 1 has priority on a tie
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/spart_bus_ctrl.sv
// Sole master of the SPART register bus: programs the divisor, drains
// received bytes and serialises two transmit requesters onto the bus.
module spart_bus_ctrl
  import spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  input  logic        rda,
  input  logic        tbr,
  spart_bus_ctrl_if.slave sys
);

  spart_state_t state_q, state_d;
  logic         init_q, init_d;
  logic [15:0]  div_q, div_d;
  logic         iorw_q, iorw_d;
  logic [1:0]   ioaddr_q, ioaddr_d;
  logic [7:0]   wdata_q, wdata_d;
  logic [7:0]   rx_data_q, rx_data_d;
  logic         rx_valid_q, rx_valid_d;
  logic         cfg_done_q, cfg_done_d;

  logic [1:0]   gnt;
  logic         rx_take, cfg_take, tx_take;

  // Accept pulses are decided in the IDLE cycle itself so a byte can be
  // taken every third cycle; bus pins are all driven from flops.
  assign rx_take  = (state_q == ST_IDLE) && rda;
  assign cfg_take = (state_q == ST_IDLE) && !rda && sys.cfg_valid;
  assign tx_take  = (state_q == ST_IDLE) && !rda && !sys.cfg_valid && tbr &&
                    (sys.tx0_valid || sys.tx1_valid);

  spart_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({sys.tx1_valid, sys.tx0_valid}),
    .accept (tx_take),
    .gnt    (gnt)
  );

  assign sys.tx0_ready = tx_take && gnt[0];
  assign sys.tx1_ready = tx_take && gnt[1];
  assign sys.cfg_ready = cfg_take;
  assign sys.rx_valid  = rx_valid_q;
  assign sys.rx_data   = rx_data_q;
  assign sys.cfg_done  = cfg_done_q;

  assign iorw    = iorw_q;
  assign ioaddr  = ioaddr_q;
  assign databus = iorw_q ? 8'bz : wdata_q;

  assign init_d = 1'b0;

  // init_q holds CFG_LO for the first cycle after reset so the bus shows
  // the reset status read before the low divisor byte goes out.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    case (state_q)
      ST_CFG_LO:  if (!init_q) state_d = ST_CFG_HI;
      ST_CFG_HI:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (rx_take) begin
          state_d = ST_RX_RD;
        end else if (cfg_take) begin
          state_d = ST_CFG_LO;
          div_d   = sys.cfg_div;
        end else if (tx_take) begin
          state_d = ST_TX_WR;
        end
      end
      ST_RX_RD:   state_d = ST_IDLE;
      ST_TX_WR:   state_d = ST_TX_WAIT;
      ST_TX_WAIT: state_d = ST_IDLE;
      default:    state_d = ST_CFG_LO;
    endcase
  end

  // Bus outputs are registered from the next state, so they always show
  // the cycle that state_q names.
  always_comb begin
    iorw_d   = 1'b1;
    ioaddr_d = ADDR_STATUS;
    wdata_d  = wdata_q;
    case (state_d)
      ST_CFG_LO: begin
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DBL;
        wdata_d  = div_d[7:0];
      end
      ST_CFG_HI: begin
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DBH;
        wdata_d  = div_d[15:8];
      end
      ST_RX_RD: ioaddr_d = ADDR_BUF;
      ST_TX_WR: begin
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_BUF;
        wdata_d  = gnt[1] ? sys.tx1_data : sys.tx0_data;
      end
      default: ;
    endcase
    cfg_done_d = !((state_d == ST_CFG_LO) || (state_d == ST_CFG_HI));
    rx_valid_d = (state_q == ST_RX_RD);
    rx_data_d  = rx_valid_d ? databus : rx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CFG_LO;
      init_q     <= 1'b1;
      div_q      <= DIV_RESET;
      iorw_q     <= 1'b1;
      ioaddr_q   <= ADDR_STATUS;
      wdata_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      div_q      <= div_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      wdata_q    <= wdata_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cfg_done_q <= cfg_done_d;
    end
  end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Bench for spart_bus_ctrl: a transaction-queue model of the bus checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_spart_bus_ctrl;
  import spart_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       rda;
  logic       tbr;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] spart_rd_val;

  spart_bus_ctrl_if sys ();

  spart_bus_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .sys     (sys)
  );

  // SPART side drives the data bus whenever the controller reads
  assign databus = iorw ? spart_rd_val : 8'bz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic       is_cfg;
  } bus_cyc_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        wr;
    logic [1:0]  addr;
    logic [7:0]  data;
  } log_t;

  bus_cyc_t mq[$];
  log_t     ops[$];
  int cnt_r0 = 0;
  int cnt_r1 = 0;
  int n_rx = 0;
  int last_rx_cyc = 0;

  // Behavioural model: each accepted operation expands into its list of
  // bus cycles; an empty list means the controller is free to decide.
  initial begin : model
    bus_cyc_t e;
    logic [15:0] dv;
    logic pre, pref0, rx_pend, cd_e, rxv_e, er0, er1, erc;
    logic [7:0] rx_pd, rxd_e;
    pre = 1'b1; pref0 = 1'b1; rx_pend = 1'b0; rx_pd = '0; rxd_e = '0;
    forever begin
      @(negedge clk);
      er0 = 1'b0; er1 = 1'b0; erc = 1'b0;
      e = '{wr: 1'b0, addr: ADDR_STATUS, data: 8'h00, is_cfg: 1'b0};
      if (!rst_n) begin
        dv = DIV_RESET;
        mq.delete();
        mq.push_back('{wr: 1'b1, addr: ADDR_DBL, data: dv[7:0], is_cfg: 1'b1});
        mq.push_back('{wr: 1'b1, addr: ADDR_DBH, data: dv[15:8], is_cfg: 1'b1});
        pre = 1'b1; pref0 = 1'b1; rx_pend = 1'b0; rxd_e = '0;
        cd_e = 1'b0; rxv_e = 1'b0;
      end else begin
        if (pre) begin
          pre = 1'b0;
          cd_e = 1'b0;
        end else if (mq.size() > 0) begin
          e = mq.pop_front();
          cd_e = !e.is_cfg;
        end else begin
          cd_e = 1'b1;
          if (rda) begin
            mq.push_back('{wr: 1'b0, addr: ADDR_BUF, data: 8'h00, is_cfg: 1'b0});
          end else if (sys.cfg_valid) begin
            erc = 1'b1;
            dv = sys.cfg_div;
            mq.push_back('{wr: 1'b1, addr: ADDR_DBL, data: dv[7:0], is_cfg: 1'b1});
            mq.push_back('{wr: 1'b1, addr: ADDR_DBH, data: dv[15:8], is_cfg: 1'b1});
          end else if (tbr && (sys.tx0_valid || sys.tx1_valid)) begin
            if (sys.tx0_valid && (!sys.tx1_valid || pref0)) er0 = 1'b1;
            else er1 = 1'b1;
            pref0 = er1;
            mq.push_back('{wr: 1'b1, addr: ADDR_BUF, data: (er0 ? sys.tx0_data : sys.tx1_data), is_cfg: 1'b0});
            mq.push_back('{wr: 1'b0, addr: ADDR_STATUS, data: 8'h00, is_cfg: 1'b0});
          end
        end
        rxv_e = rx_pend;
        if (rx_pend) rxd_e = rx_pd;
        rx_pend = 1'b0;
        if (!e.wr && e.addr == ADDR_BUF) begin
          rx_pend = 1'b1;
          rx_pd = spart_rd_val;
        end
      end
      chk("iorw", iorw, !e.wr);
      chk("ioaddr", ioaddr, e.addr);
      chk("databus", databus, e.wr ? e.data : spart_rd_val);
      chk("rx_valid", sys.rx_valid, rxv_e);
      chk("rx_data", sys.rx_data, rxd_e);
      chk("cfg_done", sys.cfg_done, cd_e);
      chk("tx0_ready", sys.tx0_ready, er0);
      chk("tx1_ready", sys.tx1_ready, er1);
      chk("cfg_ready", sys.cfg_ready, erc);
      if (rst_n) begin
        if (!iorw || ioaddr == ADDR_BUF)
          ops.push_back('{cyc: cyc, wr: !iorw, addr: ioaddr, data: databus});
        if (sys.tx0_valid && sys.tx0_ready) cnt_r0++;
        if (sys.tx1_valid && sys.tx1_ready) cnt_r1++;
        if (sys.rx_valid) begin
          n_rx++;
          last_rx_cyc = cyc;
        end
      end
    end
  end

  int tx0_left = 0;
  int tx1_left = 0;

  // Requesters keep valid up until their last byte is accepted; rda is a
  // single-cycle pulse; cfg_valid drops after its handshake.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      logic h0, h1, hc;
      @(negedge clk);
      h0 = sys.tx0_valid && sys.tx0_ready;
      h1 = sys.tx1_valid && sys.tx1_ready;
      hc = sys.cfg_valid && sys.cfg_ready;
      @(posedge clk);
      #1;
      rda = 1'b0;
      if (h0) tx0_left--;
      if (h1) tx1_left--;
      if (hc) sys.cfg_valid = 1'b0;
      sys.tx0_valid = (tx0_left > 0);
      sys.tx1_valid = (tx1_left > 0);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_tx [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
  logic [1:0] exp_oa [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
  logic [7:0] exp_od [4] = '{8'hC3, 8'h28, 8'h00, 8'h33};
  logic       exp_ow [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin : stim
    int rel, t, r0, r1, nrx0;
    logic got;
    rst_n = 1'b0; rda = 1'b0; tbr = 1'b0; spart_rd_val = 8'h5A;
    sys.tx0_valid = 1'b0; sys.tx0_data = 8'h00;
    sys.tx1_valid = 1'b0; sys.tx1_data = 8'h00;
    sys.cfg_valid = 1'b0; sys.cfg_div = 16'h0000;
    repeat (3) @(posedge clk);
    #1;

    // Reset release: divisor 0x0145 written low then high byte
    ops.delete();
    rel = cyc;
    rst_n = 1'b1;
    run(5);
    chk("rst_log_n", ops.size(), 2);
    if (ops.size() >= 2) begin
      chk("rst_lo_cyc", ops[0].cyc, rel + 1);
      chk("rst_lo_addr", ops[0].addr, 2'b10);
      chk("rst_lo_data", ops[0].data, 8'h45);
      chk("rst_hi_cyc", ops[1].cyc, rel + 2);
      chk("rst_hi_addr", ops[1].addr, 2'b11);
      chk("rst_hi_data", ops[1].data, 8'h01);
    end
    chk("rst_cfg_done", sys.cfg_done, 1'b1);

    // Receive one byte
    spart_rd_val = 8'hA5;
    ops.delete();
    nrx0 = n_rx;
    t = cyc;
    rda = 1'b1;
    run(5);
    chk("rx_log_n", ops.size(), 1);
    if (ops.size() >= 1) begin
      chk("rx_rd_cyc", ops[0].cyc, t + 1);
      chk("rx_rd_wr", ops[0].wr, 1'b0);
    end
    chk("rx_pulses", n_rx - nrx0, 1);
    chk("rx_latency", last_rx_cyc, t + 2);
    chk("rx_byte", sys.rx_data, 8'hA5);

    // Two requesters held valid: alternating grants every third cycle
    spart_rd_val = 8'h5A;
    ops.delete();
    r0 = cnt_r0; r1 = cnt_r1;
    tbr = 1'b1;
    sys.tx0_data = 8'h11; sys.tx1_data = 8'h22;
    tx0_left = 2; tx1_left = 2;
    sys.tx0_valid = 1'b1; sys.tx1_valid = 1'b1;
    run(14);
    chk("rr_log_n", ops.size(), 4);
    for (int i = 0; i < 4 && i < ops.size(); i++) begin
      chk("rr_data", ops[i].data, exp_tx[i]);
      chk("rr_addr", ops[i].addr, 2'b00);
      if (i > 0) chk("rr_spacing", ops[i].cyc - ops[i-1].cyc, 3);
    end
    chk("rr_ready0", cnt_r0 - r0, 2);
    chk("rr_ready1", cnt_r1 - r1, 2);

    // rda, cfg and tx together: rx first, then reconfig, then transmit
    spart_rd_val = 8'hC3;
    ops.delete();
    rda = 1'b1;
    sys.cfg_valid = 1'b1; sys.cfg_div = 16'h0028;
    sys.tx0_data = 8'h33; tx0_left = 1; sys.tx0_valid = 1'b1;
    run(10);
    chk("prio_log_n", ops.size(), 4);
    for (int i = 0; i < 4 && i < ops.size(); i++) begin
      chk("prio_wr", ops[i].wr, exp_ow[i]);
      chk("prio_addr", ops[i].addr, exp_oa[i]);
      chk("prio_data", ops[i].data, exp_od[i]);
    end
    chk("prio_rx_byte", sys.rx_data, 8'hC3);

    // Transmitter busy: no grant until tbr rises
    spart_rd_val = 8'h96;
    ops.delete();
    r0 = cnt_r0;
    tbr = 1'b0;
    sys.tx0_data = 8'h44; tx0_left = 1; sys.tx0_valid = 1'b1;
    run(5);
    chk("tbr_low_ops", ops.size(), 0);
    chk("tbr_low_ready", cnt_r0 - r0, 0);
    tbr = 1'b1;
    @(negedge clk);
    got = sys.tx0_valid && sys.tx0_ready;
    chk("tbr_rise_ready", got, 1'b1);
    @(posedge clk);
    #1;
    if (got) tx0_left--;
    sys.tx0_valid = (tx0_left > 0);
    run(4);
    chk("tbr_ops_n", ops.size(), 1);
    if (ops.size() >= 1) begin
      chk("tbr_addr", ops[0].addr, 2'b00);
      chk("tbr_data", ops[0].data, 8'h44);
    end

    // Reset in the middle of a transmit write
    sys.tx0_data = 8'h55; tx0_left = 1; sys.tx0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = sys.tx0_valid && sys.tx0_ready;
      @(posedge clk);
      #1;
    end
    chk("mid_rst_grant", got, 1'b1);
    tx0_left = 0; sys.tx0_valid = 1'b0;
    chk("mid_rst_pre_iorw", iorw, 1'b0);
    chk("mid_rst_pre_data", databus, 8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_iorw", iorw, 1'b1);
    chk("mid_rst_ioaddr", ioaddr, 2'b01);
    chk("mid_rst_bus_z", databus, spart_rd_val);
    @(posedge clk);
    @(posedge clk);
    #1;
    ops.delete();
    rel = cyc;
    rst_n = 1'b1;
    run(8);
    chk("post_rst_log_n", ops.size(), 2);
    if (ops.size() >= 2) begin
      chk("post_rst_lo_cyc", ops[0].cyc, rel + 1);
      chk("post_rst_lo_data", ops[0].data, 8'h45);
      chk("post_rst_hi_addr", ops[1].addr, 2'b11);
      chk("post_rst_hi_data", ops[1].data, 8'h01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_bus_ctrl.md
# spart_bus_ctrl

Bus controller for the SPART register interface. Programs the baud divisor after reset and on request, drains received bytes, and shares the transmit path between two byte requesters with round-robin fairness. Sits between the SPART core (iorw/ioaddr/databus, rda/tbr) and the system-side producers and consumer. It is the only master on the SPART bus.

## Interface
- DIV_RESET, 16'd325: baud divisor written automatically after reset.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iorw  out  1  1 = SPART read, 0 = SPART write.
- ioaddr  out  2  SPART register: 00 buffer, 01 status, 10 DB low, 11 DB high.
- databus  inout  8  driven with write data only while iorw=0, else high-Z.
- rda  in  1  SPART receive data available.
- tbr  in  1  SPART transmit buffer ready.
- tx0_valid, tx1_valid  in  1 each  requester has a byte.
- tx0_data, tx1_data  in  8 each  requester byte.
- tx0_ready, tx1_ready  out  1 each  one-cycle accept pulse; byte consumed when valid&ready.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- rx_data  out  8  last received byte, held until next rx_valid.
- cfg_valid  in  1  request divisor reprogram.
- cfg_div  in  16  new divisor; sampled on cfg_valid&cfg_ready.
- cfg_ready  out  1  one-cycle accept pulse.
- cfg_done  out  1  high when divisor programmed and bus idle-capable.

## Operation
- States: CFG_LO, CFG_HI, IDLE, RX_RD, TX_WR, TX_WAIT.
- Reset: state CFG_LO, divisor register = DIV_RESET, iorw=1, ioaddr=01, databus high-Z, all ready/valid pulses 0, rx_data=0, cfg_done=0, RR pointer favours tx0.
- CFG_LO: iorw=0, ioaddr=10, databus=div[7:0]; -> CFG_HI. CFG_HI: iorw=0, ioaddr=11, databus=div[15:8]; -> IDLE, cfg_done=1 from the IDLE cycle onward.
- IDLE: iorw=1, ioaddr=01. Decision priority: rda -> RX_RD; else cfg_valid -> pulse cfg_ready, latch cfg_div, cfg_done=0, -> CFG_LO; else tbr and any txN_valid -> grant one, pulse its ready, latch its byte, -> TX_WR; else stay.
- RX_RD: iorw=1, ioaddr=00 for one cycle; databus sampled at end of cycle into rx_data; rx_valid pulses the next cycle; -> IDLE.
- TX_WR: iorw=0, ioaddr=00, databus=latched byte for exactly one cycle; -> TX_WAIT.
- TX_WAIT: iorw=1, ioaddr=01, one cycle, tbr ignored (covers SPART status lag, prevents double send); -> IDLE.
- Round-robin: both valid -> grant the requester not granted last; one valid -> grant it. Pointer updates only on a grant.
- Requester data must be stable while valid; controller never drops an accepted byte.
- Reconfiguration only from IDLE, never mid-transaction; rda arriving during CFG/TX states is serviced on the next IDLE decision.

## Timing
- All outputs registered; no combinational path from inputs to bus outputs.
- Reset to cfg_done: 2 cycles after rst_n deassertion edge (CFG_LO, CFG_HI), cfg_done high on cycle 3.
- RX latency: rda seen in IDLE -> RX_RD next cycle -> rx_valid the cycle after (2 cycles).
- TX: ready pulse in IDLE cycle N, bus write in N+1, earliest next grant decision N+3; max throughput one byte per 3 cycles.
- rst_n assertion at any time: immediate return to reset values, including databus high-Z; in-flight byte discarded; on release configuration restarts with DIV_RESET (any runtime cfg_div lost).
- Simultaneous rda, cfg_valid, tx valid in IDLE: rda wins; cfg next IDLE; tx after.

## Structure
- Shared package spart_pkg: state enum, ioaddr constants (ADDR_BUF, ADDR_STATUS, ADDR_DBL, ADDR_DBH), DIV_RESET default.
- One sub-module spart_rr_arb: 2-way round-robin arbiter (valid in, grant one-hot out, pointer update on accept).

## Test plan
- Reset release, DIV_RESET=16'h0145 -> cycle 1 write ioaddr=10 data 8'h45, cycle 2 write ioaddr=11 data 8'h01, cfg_done=1 cycle 3, databus Z otherwise.
- rda=1 with databus=8'hA5 during RX_RD -> one rx_valid pulse 2 cycles later, rx_data=8'hA5, no write cycle.
- tx0_valid, tx1_valid both held, tbr=1, data 8'h11/8'h22 -> writes alternate 11,22,11,22 at 3-cycle spacing, exactly one ready pulse per byte.
- rda, cfg_valid (cfg_div=16'h0028), tx0_valid asserted same IDLE cycle -> order RX_RD, CFG_LO(8'h28), CFG_HI(8'h00), then TX_WR.
- tbr=0 with tx0_valid -> no ready, bus stays iorw=1/ioaddr=01; tbr rises -> grant next cycle.
- rst_n asserted during TX_WR -> databus Z and iorw=1 immediately; after release reconfigures with DIV_RESET, previous byte not resent.
